// File: rtl/single_precision_pkg.sv
// rtl/single_precision_pkg.sv - shared float constants and tag type for the multiply arbiter
//
// Purpose: common definitions for single_multiply and single_multiply_arbiter.
//   FP_WIDTH  : IEEE-754 single-precision word width
//   TAG_ID_W  : requester id field width, sized for the largest supported N_REQ (16)
//   mul_tag_t : {valid, id} entry carried alongside each in-flight product
//   FP_ZERO / FP_ONE / FP_QNAN : frequently used bit patterns

package single_precision_pkg;

  localparam int FP_WIDTH = 32;
  localparam int TAG_ID_W = 4;

  localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_WIDTH-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [FP_WIDTH-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } mul_tag_t;

endpackage

// File: rtl/single_multiply.sv
// rtl/single_multiply.sv - two-stage pipelined IEEE-754 single-precision multiplier
//
// Purpose: c = a * b, round-to-nearest-even. Product appears on c two clock
// edges after a/b are presented (a/b are expected to come from registers).
// Denormal inputs are treated as zero and underflowing results flush to zero.
// Ports:
//   clk  in  1   rising-edge clock
//   rstn in  1   asynchronous active-low reset
//   a    in  32  operand A bits
//   b    in  32  operand B bits
//   c    out 32  registered product bits

module single_multiply
  import single_precision_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic [FP_WIDTH-1:0] a,
  input  logic [FP_WIDTH-1:0] b,
  output logic [FP_WIDTH-1:0] c
);

  // Stage 1: classify, add exponents, multiply significands.
  logic               w_a_zero, w_a_inf, w_a_nan;
  logic               w_b_zero, w_b_inf, w_b_nan;
  logic               w_s1_nan, w_s1_inf, w_s1_zero, w_s1_sign;
  logic signed [9:0]  w_s1_exp;
  logic [47:0]        w_s1_prod;

  always_comb begin
    w_a_zero  = (a[30:23] == 8'h00);
    w_a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    w_a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    w_b_zero  = (b[30:23] == 8'h00);
    w_b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    w_b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    // Inf * 0 is invalid and yields NaN.
    w_s1_nan  = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
    w_s1_inf  = w_a_inf || w_b_inf;
    w_s1_zero = w_a_zero || w_b_zero;
    w_s1_sign = a[31] ^ b[31];
    w_s1_exp  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    w_s1_prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
  end

  logic               r_s1_nan, r_s1_inf, r_s1_zero, r_s1_sign;
  logic signed [9:0]  r_s1_exp;
  logic [47:0]        r_s1_prod;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_nan  <= 1'b0;
      r_s1_inf  <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_exp  <= '0;
      r_s1_prod <= '0;
    end else begin
      r_s1_nan  <= w_s1_nan;
      r_s1_inf  <= w_s1_inf;
      r_s1_zero <= w_s1_zero;
      r_s1_sign <= w_s1_sign;
      r_s1_exp  <= w_s1_exp;
      r_s1_prod <= w_s1_prod;
    end
  end

  // Stage 2: normalise (product of two 1.x values lies in [1,4)), round, pack.
  logic [22:0]        w_mant;
  logic               w_guard, w_sticky, w_round;
  logic [23:0]        w_mant_r;
  logic signed [9:0]  w_exp_n;
  logic [FP_WIDTH-1:0] w_c_next;

  always_comb begin
    if (r_s1_prod[47]) begin
      w_mant   = r_s1_prod[46:24];
      w_guard  = r_s1_prod[23];
      w_sticky = |r_s1_prod[22:0];
      w_exp_n  = r_s1_exp + 10'sd1;
    end else begin
      w_mant   = r_s1_prod[45:23];
      w_guard  = r_s1_prod[22];
      w_sticky = |r_s1_prod[21:0];
      w_exp_n  = r_s1_exp;
    end
    w_round  = w_guard && (w_sticky || w_mant[0]);
    w_mant_r = {1'b0, w_mant} + {23'd0, w_round};
    // Rounding carry out of the fraction bumps the exponent; fraction is then zero.
    if (w_mant_r[23]) begin
      w_exp_n = w_exp_n + 10'sd1;
    end

    if (r_s1_nan) begin
      w_c_next = FP_QNAN;
    end else if (r_s1_inf) begin
      w_c_next = {r_s1_sign, 8'hFF, 23'd0};
    end else if (r_s1_zero) begin
      w_c_next = {r_s1_sign, 31'd0};
    end else if (w_exp_n > 10'sd254) begin
      w_c_next = {r_s1_sign, 8'hFF, 23'd0};
    end else if (w_exp_n < 10'sd1) begin
      w_c_next = {r_s1_sign, 31'd0};
    end else begin
      w_c_next = {r_s1_sign, w_exp_n[7:0], w_mant_r[22:0]};
    end
  end

  logic [FP_WIDTH-1:0] r_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_c <= FP_ZERO;
    end else begin
      r_c <= w_c_next;
    end
  end

  assign c = r_c;

endmodule

// File: rtl/single_multiply_arbiter.sv
// rtl/single_multiply_arbiter.sv - round-robin sharing of one pipelined float multiplier
//
// Purpose: N_REQ requesters issue operand pairs over valid/ready; a round-robin
// arbiter issues at most one per cycle into single_multiply and a tag pipeline
// routes each product back to its requester.
// Ports:
//   clk        in  1           rising-edge clock
//   rstn       in  1           asynchronous active-low reset
//   req_valid  in  N_REQ       per-requester operand valid
//   req_ready  out N_REQ       one-hot grant (zero when nobody is valid or in reset)
//   req_a      in  N_REQ*32    operand A, requester i at bits [i*32 +: 32]
//   req_b      in  N_REQ*32    operand B, requester i at bits [i*32 +: 32]
//   resp_valid out N_REQ       one-hot registered pulse marking the owner of resp_data
//   resp_data  out 32          registered product, holds between pulses
//   busy       out 1           any operation in flight or being delivered

module single_multiply_arbiter
  import single_precision_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*FP_WIDTH-1:0] req_a,
  input  logic [N_REQ*FP_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]          resp_valid,
  output logic [FP_WIDTH-1:0]       resp_data,
  output logic                      busy
);

  localparam int IDW = $clog2(N_REQ);

  // (base + k) mod N_REQ for base < N_REQ and k < N_REQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) begin
      s = s - N_REQ;
    end
    return IDW'(s);
  endfunction

  logic [IDW-1:0]      r_rr_ptr;
  logic [IDW-1:0]      w_grant_idx;
  logic                w_grant_found;
  logic                w_hs;
  logic [FP_WIDTH-1:0] w_sel_a, w_sel_b;
  mul_tag_t            w_tag_in;

  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_grant_found && req_valid[wrap_idx(r_rr_ptr, k)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = wrap_idx(r_rr_ptr, k);
      end
    end
    // Gating with rstn keeps ready low while reset is held, even before the first edge.
    w_hs      = w_grant_found && rstn;
    req_ready = '0;
    if (w_hs) begin
      req_ready[w_grant_idx] = 1'b1;
    end
    w_sel_a        = req_a[int'(w_grant_idx)*FP_WIDTH +: FP_WIDTH];
    w_sel_b        = req_b[int'(w_grant_idx)*FP_WIDTH +: FP_WIDTH];
    w_tag_in.valid = w_hs;
    w_tag_in.id    = w_hs ? TAG_ID_W'(w_grant_idx) : '0;
  end

  // Stage 0 sits beside the operand registers; stages 1..MUL_LATENCY follow the
  // multiplier, so the last stage lines up with the product on w_mul_c.
  logic [FP_WIDTH-1:0] r_op_a, r_op_b;
  mul_tag_t            r_tag [0:MUL_LATENCY];
  logic [N_REQ-1:0]    r_resp_valid;
  logic [FP_WIDTH-1:0] r_resp_data;
  logic [FP_WIDTH-1:0] w_mul_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr     <= '0;
      r_op_a       <= FP_ZERO;
      r_op_b       <= FP_ZERO;
      for (int i = 0; i <= MUL_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
      r_resp_valid <= '0;
      r_resp_data  <= FP_ZERO;
    end else begin
      if (w_hs) begin
        r_rr_ptr <= (w_grant_idx == IDW'(N_REQ - 1)) ? '0 : w_grant_idx + IDW'(1);
        r_op_a   <= w_sel_a;
        r_op_b   <= w_sel_b;
      end else begin
        r_op_a   <= FP_ZERO;
        r_op_b   <= FP_ZERO;
      end
      r_tag[0] <= w_tag_in;
      for (int i = 1; i <= MUL_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      for (int i = 0; i < N_REQ; i++) begin
        r_resp_valid[i] <= r_tag[MUL_LATENCY].valid && (r_tag[MUL_LATENCY].id == TAG_ID_W'(i));
      end
      if (r_tag[MUL_LATENCY].valid) begin
        r_resp_data <= w_mul_c;
      end
    end
  end

  single_multiply u_mul (
    .clk  (clk),
    .rstn (rstn),
    .a    (r_op_a),
    .b    (r_op_b),
    .c    (w_mul_c)
  );

  logic w_busy;

  always_comb begin
    w_busy = |r_resp_valid;
    for (int i = 0; i <= MUL_LATENCY; i++) begin
      w_busy = w_busy | r_tag[i].valid;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign busy       = w_busy;

endmodule

// File: doc/single_multiply_arbiter.md
# single_multiply_arbiter

Shares one pipelined `single_multiply` (IEEE-754 single-precision, 32-bit) among `N_REQ` requesters, such as neuron or dot-product lanes. Each requester presents operand pairs on a valid/ready handshake. A round-robin arbiter issues at most one operation per cycle into the multiplier. A tag pipeline tracks every operation in flight so that each product returns to the requester that issued it. The block sits between the layer-compute lanes and the single multiplier instance.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..16).
- `MUL_LATENCY`, 2: clock cycles from a registered operand at the `single_multiply` inputs to a valid product on `c`. Must equal the latency of the instantiated multiplier.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_ready`  out  N_REQ  per-requester grant; a handshake completes on the edge where `req_valid[i] && req_ready[i]`.
- `req_a`  in  N_REQ×32  operand A per requester (IEEE-754 bits).
- `req_b`  in  N_REQ×32  operand B per requester.
- `resp_valid`  out  N_REQ  one-hot pulse: the product for requester i is on `resp_data`.
- `resp_data`  out  32  product bits, shared by all requesters.
- `busy`  out  1  high while any operation is in flight.

## Operation
- **Arbitration (combinational):**
  - The grant goes to the first `i` with `req_valid[i]`, searching from `rr_ptr` upward and wrapping from N_REQ-1 to 0.
  - `req_ready` is one-hot to the grant, or all zero when no requester is valid.
  - `req_ready` never depends on `req_ready` of another requester. There is no response backpressure, so a valid request is always granted when selected.
- **Round-robin pointer:**
  - On a handshake, `rr_ptr <= grant+1` (mod N_REQ).
  - The pointer is unchanged in idle cycles.
  - Reset value is 0.
- **Issue stage:**
  - On a handshake, the multiplier operand registers load `req_a`/`req_b` of the granted requester.
  - The tag pipeline stage 0 loads {valid=1, id=grant}.
  - With no handshake, the operand registers load 0/0 and tag stage 0 loads valid=0.
- **Tag pipeline:**
  - Shift register of depth MUL_LATENCY, each entry {valid, id[$clog2(N_REQ)-1:0]}.
  - It advances every cycle unconditionally; the multiplier is never stalled.
- **Response:**
  - When the last tag stage is valid, `resp_valid[id]` is 1 and `resp_data = c`.
  - Otherwise `resp_valid` is 0 and `resp_data` holds its last value.
  - `resp_data` and `resp_valid` are registered outputs.
- **`busy`:** OR of all tag-stage valid bits and the response register valid.
- **Ordering:** products return in issue order. Results for one requester arrive in the order that requester issued them.
- **Arithmetic:** the block never modifies operands or results. NaN, Inf and denormal handling belong entirely to `single_multiply`.

## Timing
- Reset (async assert, sync release) clears:
  - operand registers to 0,
  - all tag valids,
  - `resp_valid` to 0, `resp_data` to 0,
  - `rr_ptr` to 0.
  
  `req_ready` is 0 during reset.
- Reset asserted mid-operation discards all in-flight products; none are ever delivered after reset.
- Latency: handshake at edge T gives `resp_valid` high for exactly one cycle after edge T+MUL_LATENCY+1.
- Throughput: one operation per cycle aggregate. Back-to-back grants to the same requester are allowed when it is the only valid requester.
- All N_REQ valid at once: grants rotate through 0,1,...,N_REQ-1 (from `rr_ptr`=0), one per cycle.
- A requester dropping `req_valid` without a handshake is legal; no state changes.

## Structure
- Shared package `single_precision_pkg`:
  - `localparam` for the 32-bit float width,
  - typedef `mul_tag_t` {valid, id},
  - constants `FP_ZERO=32'h00000000` and `FP_ONE=32'h3F800000`.
- One sub-module is natural: `single_multiply`, instantiated once, with `rstn`/`clk` connected directly.
- Arbitration and the tag pipeline stay in this module.

## Test plan
- Reset, then requester 0 sends a=0x3F800000 (1.0), b=0x40A00000 (5.0). Required: only `resp_valid[0]`, with `resp_data=0x40A00000`, MUL_LATENCY+1 cycles after the handshake; `busy` falls the following cycle.
- All 4 requesters hold valid with distinct pairs (2.0×3.0, 0.0×5.0, 500×-500, 1.0×1.0). Required:
  - grants in order 0,1,2,3 on consecutive cycles;
  - responses 0x40C00000, 0x00000000, 0xC8742400, 0x3F800000 to ids 0..3 on consecutive cycles.
- Requesters 1 and 3 hold valid continuously for 8 cycles. Required: grants alternate 1,3,1,3,…; each receives 4 correct products in its own issue order.
- Reset asserted while 2 operations are in flight. Required: no `resp_valid` during or after reset until new requests; `rr_ptr` returns to 0 (the next grant with all valid goes to 0).
- Idle gaps: requester 2 sends one op, waits 3 cycles, then sends another. Required: two single-cycle `resp_valid[2]` pulses 4 cycles apart; `resp_data` holds between pulses.
